multiboot_request: RTL and testbench
====================================

MULTIBOOT_REQUEST -- requirements
Module: multiboot_request

Interface
REQ-001 Parameter POR_CYCLES, default 65536, power-on settle delay in clock cycles before any request.
REQ-002 Parameter DEBOUNCE_CYCLES, default 16384, cycles the synchronised button must be stable before a change is accepted.
REQ-003 Parameter ACK_TIMEOUT, default 1048576, cycles to wait for reboot_ack before a retry.
REQ-004 Parameter MAX_RETRY, default 3, number of re-issues allowed after the first attempt times out.
REQ-005 clock  in  1  single system clock; all logic is on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 dip  in  4  raw board DIP switches; [3:2] select the image slot, [0] enables auto-boot; asynchronous to clock.
REQ-008 btn_n  in  1  raw active-low reboot pushbutton; asynchronous to clock.
REQ-009 reboot_ack  in  1  single-cycle pulse from the downstream ICAP reboot sequencer confirming acceptance.
REQ-010 reboot_req  out  1  request to the ICAP sequencer; level, held until acknowledged or timed out.
REQ-011 reboot_addr  out  24  SPI flash byte address of the target bitstream; valid and stable whenever reboot_req=1.
REQ-012 led  out  1  status indicator.

Function
REQ-013 dip and btn_n SHALL each pass through a two-flop synchroniser before any use.
REQ-014 The state machine SHALL have states POWERUP, IDLE, REQUEST, DONE and FAIL.
REQ-015 POWERUP SHALL count POR_CYCLES cycles and then go to IDLE; if synchronised dip[0]=1 at that moment, it SHALL instead go straight to REQUEST (auto-boot, issued once per reset).
REQ-016 In IDLE, a debounced 1->0 transition of btn_n SHALL move to REQUEST on the next cycle.
REQ-017 A button already held at reset release SHALL NOT count as a press; a press requires a debounced release to be seen first.
REQ-018 On entry to REQUEST, the slot from synchronised dip[3:2] SHALL be latched: 00->0x054000, 01->0x0A8000, 10->0x0FC000, 11->0x150000; DIP changes while reboot_req=1 SHALL be ignored.
REQ-019 reboot_req SHALL be 1 exactly while in REQUEST, asserted the cycle after entry, with reboot_addr already stable.
REQ-020 reboot_ack=1 in REQUEST SHALL move to DONE on the next cycle and deassert reboot_req.
REQ-021 If no ack arrives within ACK_TIMEOUT cycles of REQUEST entry, reboot_req SHALL drop for exactly one cycle and then re-assert with the same address; the retry counter SHALL increment.
REQ-022 A timeout with the retry count already equal to MAX_RETRY SHALL move to FAIL with reboot_req=0.
REQ-023 If ack and timeout occur in the same cycle, ack SHALL win and the next state SHALL be DONE.
REQ-024 reboot_ack outside REQUEST SHALL be ignored.
REQ-025 Button presses in REQUEST, DONE or FAIL SHALL be ignored.
REQ-026 DONE and FAIL are terminal until reset.
REQ-027 led SHALL be 0 in POWERUP, 1 in IDLE, 0 in REQUEST and DONE, and in FAIL SHALL toggle every 2^22 cycles from a free-running counter.
REQ-028 All counters SHALL saturate or reset on state entry and SHALL never wrap while in use.

Reset
REQ-029 reset_n=0 SHALL immediately force the following, regardless of clock: state=POWERUP, reboot_req=0, reboot_addr=0x000000, led=0, all counters=0, synchronisers=1 (button released, DIPs high).
REQ-030 Reset asserted mid-REQUEST SHALL drop reboot_req at once; after release, the full POR delay SHALL run again.

Structure
REQ-031 Package multiboot_pkg SHALL hold the state encoding, the four slot addresses, and the SPI read opcode 0x03 used by the ICAP sequencer.
REQ-032 Synchroniser plus debounce SHALL be one sub-module, debounce_sync, instantiated once for btn_n; the DIPs use synchronisers only.

Verification
REQ-033 dip=4'b0101 held, reset released -> reboot_req rises after POR_CYCLES+sync cycles with reboot_addr=0x0A8000; ack one cycle later -> DONE, reboot_req=0, led=0.
REQ-034 dip[0]=0, slot 10, btn_n low 100 cycles then high (bounce shorter than DEBOUNCE_CYCLES) -> no request; btn_n held low >DEBOUNCE_CYCLES -> reboot_addr=0x0FC000, reboot_req=1.
REQ-035 Request with no ack -> reboot_req drops one cycle at each ACK_TIMEOUT boundary, 4 assertions total, then FAIL with led toggling every 2^22 cycles.
REQ-036 dip[3:2] changed from 00 to 11 while reboot_req=1 -> reboot_addr stays 0x054000; ack coincident with timeout -> DONE with no retry.
REQ-037 btn_n low at reset release and held -> no request until release and a fresh press; reset_n pulsed mid-REQUEST -> reboot_req=0 asynchronously, and POR runs again.

Source files
------------

// File: rtl/multiboot_pkg.sv
// multiboot_pkg: state encoding, flash slot addresses and SPI opcode for multiboot_request
package multiboot_pkg;
  typedef enum logic [2:0] {ST_POWERUP, ST_IDLE, ST_REQUEST, ST_DONE, ST_FAIL} state_t;
  localparam logic [23:0] SLOT0 = 24'h054000;
  localparam logic [23:0] SLOT1 = 24'h0A8000;
  localparam logic [23:0] SLOT2 = 24'h0FC000;
  localparam logic [23:0] SLOT3 = 24'h150000;
  localparam logic [7:0] SPI_READ_OP = 8'h03;
  function automatic logic [23:0] slot_addr(input logic [1:0] s);
    return s == 2'd0 ? SLOT0 : s == 2'd1 ? SLOT1 : s == 2'd2 ? SLOT2 : SLOT3;
  endfunction
endpackage

// File: rtl/debounce_sync.sv
// debounce_sync: two-flop synchroniser plus stability filter; press fires once per accepted 1->0
module debounce_sync #(
  parameter int CYCLES = 16384
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_n,
  output logic press
);
  localparam int W = $clog2(CYCLES + 1);
  logic [1:0] sync;
  logic cand, level_n, armed;
  logic [W-1:0] cnt;
  logic settled;
  assign settled = cnt == W'(CYCLES - 1);
  // armed only after a settled release, so a button held through reset never counts
  assign press = armed && settled && level_n && !cand;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      sync <= 2'b11;
      cand <= 1'b1;
      cnt <= '0;
      level_n <= 1'b1;
      armed <= 1'b0;
    end else begin
      sync <= {sync[0], raw_n};
      if (sync[1] != cand) begin
        cand <= sync[1];
        cnt <= '0;
      end else if (!settled) cnt <= cnt + 1'b1;
      if (settled) begin
        level_n <= cand;
        if (cand) armed <= 1'b1;
      end
    end
endmodule

// File: rtl/multiboot_request.sv
// multiboot_request: issues a retried reboot request for a DIP-selected flash image
module multiboot_request
  import multiboot_pkg::*;
#(
  parameter int POR_CYCLES = 65536,
  parameter int DEBOUNCE_CYCLES = 16384,
  parameter int ACK_TIMEOUT = 1048576,
  parameter int MAX_RETRY = 3,
  parameter int LED_DIV = 22
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  dip,
  input  logic        btn_n,
  input  logic        reboot_ack,
  output logic        reboot_req,
  output logic [23:0] reboot_addr,
  output logic        led
);
  localparam int PW = $clog2(POR_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  state_t state, state_nx;
  logic [3:0] dip_m, dip_s;
  logic [PW-1:0] por_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [RW-1:0] retry;
  logic [LED_DIV:0] blink;
  logic gap, press, por_done, timeout, retry_now, enter_req, unused_dip;
  assign unused_dip = dip_s[1];
  assign por_done = por_cnt == PW'(POR_CYCLES - 1);
  assign timeout = !gap && tmo_cnt == TW'(ACK_TIMEOUT - 1);
  assign retry_now = timeout && !reboot_ack && retry != RW'(MAX_RETRY);
  assign enter_req = state_nx == ST_REQUEST && state != ST_REQUEST;
  debounce_sync #(.CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clock(clock), .reset_n(reset_n), .raw_n(btn_n), .press(press)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= ST_POWERUP;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      ST_POWERUP: state_nx = por_done ? (dip_s[0] ? ST_REQUEST : ST_IDLE) : ST_POWERUP;
      ST_IDLE:    state_nx = press ? ST_REQUEST : ST_IDLE;
      ST_REQUEST: state_nx = gap ? ST_REQUEST : reboot_ack ? ST_DONE :
                             (timeout && retry == RW'(MAX_RETRY)) ? ST_FAIL : ST_REQUEST;
      default:    state_nx = state;
    endcase
  end
  always_comb begin
    reboot_req = state == ST_REQUEST && !gap;
    led = state == ST_IDLE || (state == ST_FAIL && blink[LED_DIV]);
  end
  // gap is the single idle cycle between a timed-out attempt and its retry
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      dip_m <= 4'hF;
      dip_s <= 4'hF;
      por_cnt <= '0;
      tmo_cnt <= '0;
      retry <= '0;
      gap <= 1'b0;
      blink <= '0;
      reboot_addr <= '0;
    end else begin
      dip_m <= dip;
      dip_s <= dip_m;
      blink <= blink + 1'b1;
      if (state == ST_POWERUP && !por_done) por_cnt <= por_cnt + 1'b1;
      if (enter_req) begin
        reboot_addr <= slot_addr(dip_s[3:2]);
        tmo_cnt <= '0;
        retry <= '0;
        gap <= 1'b0;
      end else if (state == ST_REQUEST) begin
        gap <= retry_now;
        tmo_cnt <= (gap || retry_now) ? '0 : timeout ? tmo_cnt : tmo_cnt + 1'b1;
        if (retry_now) retry <= retry + 1'b1;
      end
    end
endmodule

// File: tb/tb_multiboot_request.sv
// tb_multiboot_request: directed checks of auto-boot, button press, retry/fail, DIP latch and reset
module tb_multiboot_request;
  localparam int POR = 64, DEB = 128, ACK = 50, MAXR = 3, LDIV = 4;
  logic clock = 1'b0, reset_n = 1'b0, btn_n = 1'b1, reboot_ack = 1'b0;
  logic [3:0] dip = 4'b0000;
  logic reboot_req, led, l0;
  logic [23:0] reboot_addr;
  int tests = 0, errors = 0, n;

  multiboot_request #(
    .POR_CYCLES(POR), .DEBOUNCE_CYCLES(DEB), .ACK_TIMEOUT(ACK), .MAX_RETRY(MAXR), .LED_DIV(LDIV)
  ) dut (
    .clock(clock), .reset_n(reset_n), .dip(dip), .btn_n(btn_n), .reboot_ack(reboot_ack),
    .reboot_req(reboot_req), .reboot_addr(reboot_addr), .led(led)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(posedge clock);
    #1;
  endtask

  task automatic wait_req(input logic v, input int budget, output int cnt);
    cnt = 0;
    while (reboot_req !== v && cnt < budget) begin
      tick(1);
      cnt++;
    end
  endtask

  task automatic start(input logic [3:0] d, input logic b, input string tag);
    reset_n = 1'b0;
    dip = d;
    btn_n = b;
    #1;
    check({tag, "_rst_req"}, reboot_req, 0);
    check({tag, "_rst_addr"}, reboot_addr, 0);
    check({tag, "_rst_led"}, led, 0);
    tick(3);
    reset_n = 1'b1;
  endtask

  initial begin
    // auto-boot from slot 01, ack one cycle after the request
    start(4'b0101, 1'b1, "auto");
    tick(5);
    check("por_led", led, 0);
    check("por_req", reboot_req, 0);
    wait_req(1'b1, POR + 20, n);
    check("auto_rise", reboot_req, 1);
    check("auto_latency", (n >= POR - 5 && n <= POR + 3) ? 1 : 0, 1);
    check("auto_addr", reboot_addr, 24'h0A8000);
    check("auto_led", led, 0);
    reboot_ack = 1'b1;
    tick(1);
    reboot_ack = 1'b0;
    check("auto_done_req", reboot_req, 0);
    check("auto_done_led", led, 0);
    tick(2 * ACK);
    check("auto_done_stays", reboot_req, 0);

    // button press with slot 10; short bounce ignored, then retries to failure
    start(4'b1000, 1'b1, "btn");
    tick(POR + 10);
    check("idle_led", led, 1);
    check("idle_req", reboot_req, 0);
    tick(DEB + 50);
    reboot_ack = 1'b1;
    tick(1);
    reboot_ack = 1'b0;
    tick(2);
    check("idle_ack_ignored", reboot_req, 0);
    check("idle_ack_led", led, 1);
    btn_n = 1'b0;
    tick(100);
    btn_n = 1'b1;
    tick(3 * DEB);
    check("bounce_no_req", reboot_req, 0);
    btn_n = 1'b0;
    wait_req(1'b1, DEB + 40, n);
    check("press_rise", reboot_req, 1);
    check("press_latency", (n >= DEB && n <= DEB + 5) ? 1 : 0, 1);
    check("press_addr", reboot_addr, 24'h0FC000);
    btn_n = 1'b1;
    for (int i = 0; i <= MAXR; i++) begin
      n = 0;
      while (reboot_req === 1'b1 && n < 3 * ACK) begin
        tick(1);
        n++;
      end
      check($sformatf("retry%0d_high", i), n, ACK);
      if (i < MAXR) begin
        n = 0;
        while (reboot_req === 1'b0 && n < 10) begin
          tick(1);
          n++;
        end
        check($sformatf("retry%0d_gap", i), n, 1);
        check($sformatf("retry%0d_addr", i), reboot_addr, 24'h0FC000);
      end
    end
    tick(2 * ACK);
    check("fail_req", reboot_req, 0);
    l0 = led;
    n = 0;
    while (led === l0 && n < 40) begin
      tick(1);
      n++;
    end
    check("fail_led_toggles", (n < 40) ? 1 : 0, 1);
    for (int i = 0; i < 2; i++) begin
      l0 = led;
      n = 0;
      while (led === l0 && n < 40) begin
        tick(1);
        n++;
      end
      check($sformatf("fail_led_period%0d", i), n, 16);
    end

    // slot latched at entry; ack coincident with timeout wins
    start(4'b0001, 1'b1, "latch");
    wait_req(1'b1, POR + 20, n);
    check("latch_rise", reboot_req, 1);
    check("latch_addr0", reboot_addr, 24'h054000);
    dip = 4'b1101;
    tick(10);
    check("latch_addr_held", reboot_addr, 24'h054000);
    tick(ACK - 11);
    check("latch_pre_tmo_req", reboot_req, 1);
    reboot_ack = 1'b1;
    tick(1);
    reboot_ack = 1'b0;
    check("ack_tmo_req", reboot_req, 0);
    tick(5);
    check("ack_tmo_no_retry", reboot_req, 0);
    check("ack_tmo_led", led, 0);

    // button held through reset release, then release, fresh press, reset mid-request
    start(4'b0000, 1'b0, "held");
    tick(POR + 3 * DEB);
    check("held_no_req", reboot_req, 0);
    check("held_idle_led", led, 1);
    btn_n = 1'b1;
    tick(2 * DEB);
    check("released_no_req", reboot_req, 0);
    btn_n = 1'b0;
    wait_req(1'b1, DEB + 40, n);
    check("fresh_press_rise", reboot_req, 1);
    check("fresh_press_addr", reboot_addr, 24'h054000);
    tick(5);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_req", reboot_req, 0);
    check("async_rst_addr", reboot_addr, 0);
    btn_n = 1'b1;
    dip = 4'b0001;
    tick(2);
    reset_n = 1'b1;
    tick(POR - 10);
    check("por_again_no_req", reboot_req, 0);
    wait_req(1'b1, 40, n);
    check("por_again_rise", reboot_req, 1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
